// File: rtl/dmem_pkg.sv
// Shared types and limits for the handshaked data memory.
// Size encodings match the request-side 2-bit size field.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_X
  } size_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int WAIT_STATES_MAX = 7;

endpackage

// File: rtl/dmem_align.sv
// Byte-lane alignment: store lane mask/replication and load extraction/extension.
// Purely combinational, no latency, no backpressure.
module dmem_align
  import dmem_pkg::*;
(
  input  size_t       size,
  input  logic        uns,
  input  logic [1:0]  lo,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  output logic [3:0]  be,
  output logic [31:0] wlane,
  output logic [31:0] ldata
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b     = word[{lo, 3'b000} +: 8];
    h     = lo[1] ? word[31:16] : word[15:0];
    be    = 4'b0000;
    wlane = 32'h0;
    ldata = 32'h0;
    case (size)
      SZ_B: begin
        be    = 4'b0001 << lo;
        wlane = {4{wdata[7:0]}};
        ldata = uns ? {24'h0, b} : {{24{b[7]}}, b};
      end
      SZ_H: begin
        be    = lo[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata[15:0]}};
        ldata = uns ? {16'h0, h} : {{16{h[15]}}, h};
      end
      SZ_W: begin
        be    = 4'b1111;
        wlane = wdata;
        ldata = word;
      end
      default: begin
        be    = 4'b0000;
        wlane = 32'h0;
        ldata = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_handshake.sv
// Data memory with req/ready handshake: IDLE -> (WAIT) -> RESP, one request in flight.
// Latency WAIT_STATES+1 (faults: 1); new requests only accepted in IDLE.
module dmem_handshake
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  uns,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic                  busy
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int LW = AW + 2;
  localparam int WS = (WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX : WAIT_STATES;
  localparam logic [2:0] WS_LOAD = (WS > 0) ? 3'(WS - 1) : 3'd0;

  logic [DATA_WIDTH-1:0] DMEM [MEM_DEPTH];

  state_t         state;
  logic [2:0]     cnt;
  logic           q_we;
  size_t          q_size;
  logic           q_uns;
  logic [LW-1:0]  q_addr;
  logic [31:0]    q_wdata;

  logic           from_idle;
  logic           c_we;
  size_t          c_size;
  logic           c_uns;
  logic [LW-1:0]  c_addr;
  logic [31:0]    c_wdata;
  logic           fault;
  logic           access;
  logic           mem_wr;
  logic [AW-1:0]  idx;
  logic [3:0]     be;
  logic [31:0]    wlane;
  logic [31:0]    ldata;

  always_comb begin
    fault = 1'b0;
    case (size_t'(size))
      SZ_H:    fault = addr[0];
      SZ_W:    fault = (addr[1:0] != 2'b00);
      SZ_X:    fault = 1'b1;
      default: fault = 1'b0;
    endcase
    if (addr[31:2] >= 30'(MEM_DEPTH)) fault = 1'b1;
  end

  // With zero wait states the access happens on the accepting edge, so use live inputs.
  assign from_idle = (state == IDLE);
  assign c_we      = from_idle ? we               : q_we;
  assign c_size    = from_idle ? size_t'(size)    : q_size;
  assign c_uns     = from_idle ? uns              : q_uns;
  assign c_addr    = from_idle ? addr[LW-1:0]     : q_addr;
  assign c_wdata   = from_idle ? wdata            : q_wdata;
  assign idx       = c_addr[LW-1:2];

  assign access = RESET_N &&
                  ((from_idle && req && !fault && (WS == 0)) ||
                   ((state == WAIT) && (cnt == 3'd0)));
  assign mem_wr = access && c_we;

  dmem_align u_align (
    .size  (c_size),
    .uns   (c_uns),
    .lo    (c_addr[1:0]),
    .wdata (c_wdata),
    .word  (DMEM[idx]),
    .be    (be),
    .wlane (wlane),
    .ldata (ldata)
  );

  always_ff @(posedge CLK) begin
    if (mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) DMEM[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      ready   <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
      q_we    <= 1'b0;
      q_size  <= SZ_B;
      q_uns   <= 1'b0;
      q_addr  <= '0;
      q_wdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          rdata <= '0;
          err   <= 1'b0;
          if (req) begin
            q_we    <= we;
            q_size  <= size_t'(size);
            q_uns   <= uns;
            q_addr  <= addr[LW-1:0];
            q_wdata <= wdata;
            busy    <= 1'b1;
            if (fault) begin
              state <= RESP;
              ready <= 1'b1;
              err   <= 1'b1;
            end else if (WS == 0) begin
              state <= RESP;
              ready <= 1'b1;
              rdata <= we ? '0 : ldata;
            end else begin
              state <= WAIT;
              cnt   <= WS_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            state <= RESP;
            ready <= 1'b1;
            err   <= 1'b0;
            rdata <= q_we ? '0 : ldata;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          ready <= 1'b0;
          rdata <= '0;
          err   <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
          rdata <= '0;
          err   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
